// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480 timing constants, rgb type and colour-bar table
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_COLOR_W  = 8;

  typedef struct packed {
    logic [VGA_COLOR_W-1:0] r;
    logic [VGA_COLOR_W-1:0] g;
    logic [VGA_COLOR_W-1:0] b;
  } rgb_t;

  // {r,g,b} full-scale enables, bar 0 (white) in the low slot, bar 7 (black) in the high slot
  localparam logic [7:0][2:0] BAR_TABLE = {3'b000, 3'b001, 3'b100, 3'b101,
                                           3'b010, 3'b011, 3'b110, 3'b111};
endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop key synchroniser, stability counter and press strobe
module key_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n_i,
  output logic pressed_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  // the DEBOUNCE_CYC-th consecutive differing sample flips the debounced state
  assign flip      = (sync2_q != db_q) && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
  assign pressed_o = flip && !sync2_q;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (flip) begin
      db_d = sync2_q;
    end else if (sync2_q != db_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/vga_display_core.sv
// rtl/vga_display_core.sv - VGA timing, frame-aligned key commands, sync/blank delay pipe
// Optional colour-bar override selected by defining VGA_COLORBAR_EN.
module vga_display_core
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_FP         = VGA_H_FP,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BP         = VGA_H_BP,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_FP         = VGA_V_FP,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BP         = VGA_V_BP,
  parameter int COLOR_W      = VGA_COLOR_W,
  parameter int N_KEYS       = 3,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int PIPE_DLY     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_KEYS-1:0]    key_n,
  input  logic [3*COLOR_W-1:0] pix_rgb,
  input  logic                 bar_sel,
  output logic [9:0]           hcount,
  output logic [9:0]           vcount,
  output logic                 frame_start,
  output logic [N_KEYS-1:0]    cmd,
  output logic                 hsync_n,
  output logic                 vsync_n,
  output logic                 blank_n,
  output logic                 sync_n,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue
);
  localparam int         H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_COLORBAR_EN
  localparam int PW = 6;
`else
  localparam int PW = 3;
`endif
  localparam logic [PW-1:0] IDLE = PW'(3'b110);

  logic [9:0]           h_q, h_d, v_q, v_d;
  logic                 frame_start_q;
  logic [N_KEYS-1:0]    pend_q, pend_d, press;
  logic                 release_pt;
  logic                 raw_hs_n, raw_vs_n, raw_act;
  logic [PW-1:0]        raw, dly;
  logic [3*COLOR_W-1:0] src, rgb_q;
  logic                 hs_q, vs_q, bl_q;

  always_comb begin
    h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clock     (clock),
      .reset     (reset),
      .key_n_i   (key_n[k]),
      .pressed_o (press[k])
    );
  end

  // a press landing on the release cycle is kept for the following frame
  assign release_pt = (h_q == 10'd0) && (v_q == V_ACT);
  assign pend_d     = (release_pt ? '0 : pend_q) | press;
  assign cmd        = release_pt ? pend_q : '0;

  assign raw_hs_n = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign raw_vs_n = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign raw_act  = (h_q < H_ACT) && (v_q < V_ACT);

`ifdef VGA_COLORBAR_EN
  logic [2:0] bar_code;
  assign raw      = {3'(h_q / 10'(H_ACTIVE / 8)), raw_hs_n, raw_vs_n, raw_act};
  assign bar_code = BAR_TABLE[dly[5:3]];
  assign src      = bar_sel ? {{COLOR_W{bar_code[2]}}, {COLOR_W{bar_code[1]}}, {COLOR_W{bar_code[0]}}}
                            : pix_rgb;
`else
  logic unused_bar_sel;
  assign unused_bar_sel = bar_sel;
  assign raw            = {raw_hs_n, raw_vs_n, raw_act};
  assign src            = pix_rgb;
`endif

  if (PIPE_DLY == 0) begin : g_nopipe
    assign dly = raw;
  end else begin : g_pipe
    logic [PW-1:0] sr_q [PIPE_DLY];
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DLY; i++) sr_q[i] <= IDLE;
      end else begin
        sr_q[0] <= raw;
        for (int i = 1; i < PIPE_DLY; i++) sr_q[i] <= sr_q[i-1];
      end
    end
    assign dly = sr_q[PIPE_DLY-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
      pend_q        <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      bl_q          <= 1'b0;
      rgb_q         <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= (h_d == H_LAST) && (v_d == V_LAST);
      pend_q        <= pend_d;
      hs_q          <= dly[2];
      vs_q          <= dly[1];
      bl_q          <= dly[0];
      rgb_q         <= dly[0] ? src : '0;
    end
  end

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign frame_start = frame_start_q;
  assign hsync_n     = hs_q;
  assign vsync_n     = vs_q;
  assign blank_n     = bl_q;
  assign sync_n      = 1'b0;
  assign red         = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue        = rgb_q[COLOR_W-1:0];
endmodule
